// File: rtl/bnn_popcount_accum.sv
// Accumulates N_CHUNKS per-chunk XNOR popcounts into one neuron, then emits the
// popcount total, the signed bipolar dot product and a thresholded activation bit.
module bnn_popcount_accum #(
  parameter int BW_BUS   = 9,
  parameter int N_CHUNKS = 4,
  parameter int BW_POP   = $clog2(BW_BUS + 1),
  parameter int BW_ACC   = $clog2(BW_BUS * N_CHUNKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [BW_POP-1:0] i_pop,
  input  logic [BW_ACC-1:0] i_thr,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BW_ACC-1:0] o_sum,
  output logic [BW_ACC:0]   o_dot,
  output logic              o_bit,
  output logic              o_err
);

  localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CW-1:0]     LAST    = CW'(N_CHUNKS - 1);
  localparam logic [BW_POP-1:0] POP_MAX = BW_POP'(BW_BUS);
  localparam logic [BW_ACC+1:0] FULL    = (BW_ACC + 2)'(BW_BUS * N_CHUNKS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW_ACC-1:0] acc;
  logic [BW_ACC-1:0] thr_q;

  logic              accept;
  logic              first;
  logic              last;
  logic              pop_over;
  logic [BW_POP-1:0] pop_c;
  logic [BW_ACC-1:0] nxt_sum;
  logic [BW_ACC-1:0] thr_use;
  logic [BW_ACC+1:0] dot_wide;

  // While a result is pending, a new beat may only enter on the consume cycle.
  assign i_ready  = (state == ACCUM) ? 1'b1 : o_ready;
  assign accept   = i_valid && i_ready;
  assign first    = (cnt == '0);
  assign last     = (cnt == LAST);
  assign pop_over = (i_pop > POP_MAX);
  assign pop_c    = pop_over ? POP_MAX : i_pop;
  assign nxt_sum  = first ? BW_ACC'(pop_c) : acc + BW_ACC'(pop_c);
  // A single-beat window must compare against the threshold arriving with that beat.
  assign thr_use  = first ? i_thr : thr_q;
  assign dot_wide = {1'b0, nxt_sum, 1'b0} - FULL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc     <= '0;
      thr_q   <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_dot   <= '0;
      o_bit   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      if (state == HOLD && o_ready) begin
        o_valid <= 1'b0;
        state   <= ACCUM;
      end
      if (accept) begin
        if (pop_over)
          o_err <= 1'b1;
        if (first)
          thr_q <= i_thr;
        acc <= nxt_sum;
        if (last) begin
          cnt     <= '0;
          o_sum   <= nxt_sum;
          o_dot   <= dot_wide[BW_ACC:0];
          o_bit   <= (nxt_sum >= thr_use);
          o_valid <= 1'b1;
          state   <= HOLD;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_popcount_accum.sv
// Directed-vector bench for bnn_popcount_accum (BW_BUS=9, N_CHUNKS=4) with
// hand-computed window results.
module tb_bnn_popcount_accum;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] i_pop;
  logic [5:0] i_thr;
  logic       o_valid;
  logic       o_ready;
  logic [5:0] o_sum;
  logic [6:0] o_dot;
  logic       o_bit;
  logic       o_err;

  int checkCount;
  int errorCount;

  bnn_popcount_accum #(.BW_BUS(9), .N_CHUNKS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_pop   (i_pop),
    .i_thr   (i_thr),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_sum   (o_sum),
    .o_dot   (o_dot),
    .o_bit   (o_bit),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: drive one beat, advance to the next falling edge.
  task automatic applyStimulus(input int pop, input int thr);
    i_valid = 1'b1;
    i_pop   = 4'(pop);
    i_thr   = 6'(thr);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkWindow(input string tag, input int sum, input int dot, input int bitv);
    checkOutput({tag, "_valid"}, int'(o_valid), 1);
    checkOutput({tag, "_sum"}, int'(o_sum), sum);
    checkOutput({tag, "_dot"}, int'($signed(o_dot)), dot);
    checkOutput({tag, "_bit"}, int'(o_bit), bitv);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_pop   = '0;
    i_thr   = '0;
    o_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", int'(o_valid), 0);
    checkOutput("rst_sum", int'(o_sum), 0);
    checkOutput("rst_dot", int'(o_dot), 0);
    checkOutput("rst_bit", int'(o_bit), 0);
    checkOutput("rst_err", int'(o_err), 0);
    checkOutput("rst_iready", int'(i_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones window, then windows issued back-to-back without a bubble
    applyStimulus(9, 18);
    applyStimulus(9, 0);
    applyStimulus(9, 0);
    checkOutput("w1_latency", int'(o_valid), 0);
    applyStimulus(9, 0);
    checkWindow("w1", 36, 36, 1);

    applyStimulus(0, 1);
    checkOutput("w2_consumed", int'(o_valid), 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkWindow("w2", 0, -36, 0);

    applyStimulus(5, 18);
    applyStimulus(4, 0);
    applyStimulus(5, 0);
    applyStimulus(4, 0);
    checkWindow("w3", 18, 0, 1);

    applyStimulus(5, 19);
    applyStimulus(4, 0);
    applyStimulus(5, 0);
    applyStimulus(4, 0);
    checkWindow("w4", 18, 0, 0);

    // Threshold is taken from the first beat only
    applyStimulus(9, 10);
    applyStimulus(9, 40);
    applyStimulus(9, 40);
    applyStimulus(9, 40);
    checkWindow("thr_lo", 36, 36, 1);

    applyStimulus(9, 40);
    applyStimulus(9, 10);
    applyStimulus(9, 10);
    applyStimulus(9, 10);
    checkWindow("thr_hi", 36, 36, 0);

    idle(1);
    checkOutput("idle_valid", int'(o_valid), 0);

    // Backpressure with a gap mid-window
    o_ready = 1'b0;
    applyStimulus(1, 5);
    applyStimulus(2, 0);
    idle(2);
    applyStimulus(3, 0);
    applyStimulus(4, 0);
    checkWindow("bp", 10, -16, 1);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_pop   = 4'd5;
      i_thr   = 6'd0;
      #1;
      checkOutput("bp_iready", int'(i_ready), 0);
      @(negedge clk);
      checkWindow("bp_hold", 10, -16, 1);
    end
    o_ready = 1'b1;
    applyStimulus(7, 13);
    checkOutput("bp_consumed", int'(o_valid), 0);
    applyStimulus(2, 0);
    applyStimulus(2, 0);
    applyStimulus(2, 0);
    checkWindow("bp_next", 13, -10, 1);

    // Out-of-range popcount clamps and sets the sticky error
    applyStimulus(12, 9);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkWindow("clamp", 9, -18, 1);
    checkOutput("clamp_err", int'(o_err), 1);

    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkWindow("sticky", 4, -28, 1);
    checkOutput("sticky_err", int'(o_err), 1);

    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", int'(o_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-window discards the partial sum
    applyStimulus(9, 0);
    applyStimulus(9, 0);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid", int'(o_valid), 0);
    applyStimulus(1, 5);
    applyStimulus(1, 0);
    checkOutput("abort_no_result", int'(o_valid), 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkWindow("abort_new", 4, -28, 0);
    checkOutput("abort_err", int'(o_err), 0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bnn_popcount_accum.md
# bnn_popcount_accum

Downstream stage of the single-binary XNOR/popcount dot-product kernel. Accepts one per-chunk popcount per beat over a valid/ready handshake and accumulates N_CHUNKS beats into one output neuron. Converts the total into a signed bipolar dot product and a binary activation by threshold compare. Presents the result on a held valid/ready output port.

## Interface
- BW_BUS, 9: width of one kernel chunk; maximum legal popcount per beat.
- N_CHUNKS, 4: beats per output window; must be ≥1.
- BW_POP, $clog2(BW_BUS+1): derived; per-beat popcount width.
- BW_ACC, $clog2(BW_BUS*N_CHUNKS+1): derived; accumulator and threshold width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  beat valid.
- i_ready  out  1  beat accepted when i_valid && i_ready at a clk edge.
- i_pop  in  BW_POP  popcount of one chunk from the kernel stage.
- i_thr  in  BW_ACC  unsigned activation threshold on the popcount total.
- o_valid  out  1  result valid; held until accepted.
- o_ready  in  1  result consumed when o_valid && o_ready at a clk edge.
- o_sum  out  BW_ACC  popcount total of the window.
- o_dot  out  BW_ACC+1  signed bipolar dot product, 2*o_sum − BW_BUS*N_CHUNKS.
- o_bit  out  1  activation, 1 iff o_sum ≥ window threshold.
- o_err  out  1  sticky: an out-of-range i_pop was seen since reset.

## Operation
- Two states: ACCUM (collecting beats) and HOLD (result valid, waiting for o_ready).
- Beat counter cnt runs 0..N_CHUNKS−1. Accumulator acc is BW_ACC bits wide and can never overflow.
- ACCUM:
  - i_ready=1.
  - On an accepted beat, acc += clamp(i_pop) and cnt increments.
  - On the first beat of a window (cnt==0), acc loads clamp(i_pop) and i_thr is captured into thr_q. i_thr is ignored for the rest of the window.
  - When the accepted beat has cnt==N_CHUNKS−1, the block registers o_sum, o_dot and o_bit, sets o_valid=1, clears cnt and moves to HOLD.
- HOLD:
  - i_ready = o_ready, combinational pass-through.
  - If o_valid && o_ready: o_valid drops next cycle.
    - If i_valid is also high in that cycle, that beat is accepted as the first beat of the next window.
    - If N_CHUNKS==1, that beat completes a new window: stay in HOLD with new outputs and o_valid=1.
    - Otherwise go to ACCUM.
  - If o_ready=0: o_sum, o_dot, o_bit and o_valid hold stable and no beat is accepted.
- Clamp rule: i_pop > BW_BUS is treated as BW_BUS and sets o_err=1. o_err is cleared only by reset.
- o_dot is computed in BW_ACC+2 bits, then truncated to BW_ACC+1 bits. The result is exact for the range −BW_BUS*N_CHUNKS..+BW_BUS*N_CHUNKS.
- o_bit = (o_sum ≥ thr_q), unsigned compare.

## Timing
- Reset (rst_n low, asynchronous):
  - State=ACCUM, cnt=0, acc=0, thr_q=0.
  - o_valid=0, o_sum=0, o_dot=0, o_bit=0, o_err=0.
  - i_ready=1 in the reset state. The bench keeps i_valid low during reset.
- Latency: o_valid rises on the clk edge that accepts the last beat of a window. Results are visible 1 cycle after that beat is presented.
- Throughput: one beat per cycle sustained with o_ready=1. There is no bubble between windows.
- Outputs change only on the o_valid rising edge or on a consume edge. They never change while o_valid=1 && o_ready=0.
- Reset mid-window or during HOLD discards the partial sum and the pending result. The first beat accepted after release starts a new window.
- i_valid low mid-window: acc and cnt hold. Gaps of any length are allowed.

## Test plan
- BW_BUS=9, N_CHUNKS=4, i_thr=18, beats 9,9,9,9 back-to-back, o_ready=1 -> o_valid 1 cycle after 4th beat; o_sum=36, o_dot=+36, o_bit=1.
- Beats 0,0,0,0 with i_thr=1 -> o_sum=0, o_dot=−36, o_bit=0. Beats 5,4,5,4 with i_thr=18 -> o_sum=18, o_dot=0, o_bit=1. Same beats with i_thr=19 -> o_bit=0.
- Threshold capture: i_thr=10 on beat 1, changed to 30 for beats 2–4, beats 9,9,9,9 -> o_bit=1 (uses 10).
- Backpressure: window completes with o_ready=0 for 3 cycles -> outputs stable and i_ready=0 for those 3 cycles. Then o_ready=1 with i_valid=1, i_pop=7 -> result consumed; next window sums 7+…; no beat lost or duplicated.
- Clamp: beats 12,0,0,0 -> o_sum=9, o_err=1. o_err stays 1 across later windows until rst_n pulses low.
- Reset mid-window: beats 9,9, then rst_n low 1 cycle, then beats 1,1,1,1 -> o_sum=4, o_dot=−28; no result emitted for the aborted window.
